// File: rtl/axi_decerr_responder.sv
// axi_decerr_responder: terminating AXI4 subordinate that answers every request
// with DECERR so no initiator hangs behind an isolated or unmapped port.
// One write and one read transaction are tracked independently.
// Optional build macro: AXI_DECERR_RESPONDER_ATOP_EN. When defined, an atomic
// with a read response (aw_atop_i[5]) also receives aw_len_i+1 R beats.
//
// state  | meaning
// W_IDLE | waiting for AW (held off while an atop read is pending)
// W_DATA | draining W beats until w_last
// W_RESP | presenting B until accepted
// R_IDLE | waiting for AR (pending atop served first)
// R_DATA | streaming R beats, cnt_q beats remain after the current one
module axi_decerr_responder #(
  parameter int unsigned IdWidth   = 4,
  parameter int unsigned DataWidth = 64,
  parameter logic [63:0] RespData  = 64'hBADCAB1E
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [IdWidth-1:0]   aw_id_i,
  input  logic [7:0]           aw_len_i,
  input  logic [5:0]           aw_atop_i,
  input  logic                 aw_valid_i,
  output logic                 aw_ready_o,
  input  logic                 w_last_i,
  input  logic                 w_valid_i,
  output logic                 w_ready_o,
  output logic [IdWidth-1:0]   b_id_o,
  output logic [1:0]           b_resp_o,
  output logic                 b_valid_o,
  input  logic                 b_ready_i,
  input  logic [IdWidth-1:0]   ar_id_i,
  input  logic [7:0]           ar_len_i,
  input  logic                 ar_valid_i,
  output logic                 ar_ready_o,
  output logic [IdWidth-1:0]   r_id_o,
  output logic [DataWidth-1:0] r_data_o,
  output logic [1:0]           r_resp_o,
  output logic                 r_last_o,
  output logic                 r_valid_o,
  input  logic                 r_ready_i
);

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_e;

  w_state_e           w_state_q, w_state_d;
  r_state_e           r_state_q, r_state_d;
  logic [IdWidth-1:0] b_id_q, r_id_q;
  logic [7:0]         cnt_q;
  logic               load_atop;
  logic               atop_pending;
  logic [IdWidth-1:0] atop_id;
  logic [7:0]         atop_len;

`ifdef AXI_DECERR_RESPONDER_ATOP_EN
  logic               atop_vld_q;
  logic [IdWidth-1:0] atop_id_q;
  logic [7:0]         atop_len_q;

  // One-entry holding register for an atomic that still owes a read burst
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      atop_vld_q <= 1'b0;
      atop_id_q  <= '0;
      atop_len_q <= '0;
    end else if (load_atop) begin
      atop_vld_q <= 1'b0;
    end else if (aw_ready_o && aw_valid_i && aw_atop_i[5]) begin
      atop_vld_q <= 1'b1;
      atop_id_q  <= aw_id_i;
      atop_len_q <= aw_len_i;
    end
  end

  assign atop_pending = atop_vld_q;
  assign atop_id      = atop_id_q;
  assign atop_len     = atop_len_q;
`else
  // Atomics get only a B; their length and opcode carry no meaning here.
  logic unused_atop;
  assign unused_atop  = ^{aw_len_i, aw_atop_i};
  assign atop_pending = 1'b0;
  assign atop_id      = '0;
  assign atop_len     = '0;
`endif

  // State registers for both channels
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      w_state_q <= W_IDLE;
      r_state_q <= R_IDLE;
    end else begin
      w_state_q <= w_state_d;
      r_state_q <= r_state_d;
    end
  end

  // Write FSM: accept AW, drain W to w_last, present B
  always_comb begin
    w_state_d  = w_state_q;
    aw_ready_o = 1'b0;
    w_ready_o  = 1'b0;
    b_valid_o  = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        aw_ready_o = !atop_pending;
        if (aw_valid_i && !atop_pending) w_state_d = W_DATA;
      end
      W_DATA: begin
        w_ready_o = 1'b1;
        if (w_valid_i && w_last_i) w_state_d = W_RESP;
      end
      W_RESP: begin
        b_valid_o = 1'b1;
        if (b_ready_i) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
    if (rst_i) begin
      aw_ready_o = 1'b0;
      w_ready_o  = 1'b0;
      b_valid_o  = 1'b0;
    end
  end

  // Read FSM: pending atop has priority over a new AR, then stream beats
  always_comb begin
    r_state_d  = r_state_q;
    ar_ready_o = 1'b0;
    r_valid_o  = 1'b0;
    load_atop  = 1'b0;
    case (r_state_q)
      R_IDLE: begin
        if (atop_pending) begin
          load_atop = 1'b1;
          r_state_d = R_DATA;
        end else begin
          ar_ready_o = 1'b1;
          if (ar_valid_i) r_state_d = R_DATA;
        end
      end
      R_DATA: begin
        r_valid_o = 1'b1;
        if (r_ready_i && (cnt_q == 8'd0)) r_state_d = R_IDLE;
      end
      default: r_state_d = R_IDLE;
    endcase
    if (rst_i) begin
      ar_ready_o = 1'b0;
      r_valid_o  = 1'b0;
      load_atop  = 1'b0;
    end
  end

  // Latched IDs and the remaining-beat down-counter (stops at zero, never wraps)
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      b_id_q <= '0;
      r_id_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (aw_ready_o && aw_valid_i) b_id_q <= aw_id_i;
      if (load_atop) begin
        r_id_q <= atop_id;
        cnt_q  <= atop_len;
      end else if (ar_ready_o && ar_valid_i) begin
        r_id_q <= ar_id_i;
        cnt_q  <= ar_len_i;
      end else if (r_valid_o && r_ready_i && (cnt_q != 8'd0)) begin
        cnt_q <= cnt_q - 8'd1;
      end
    end
  end

  assign b_id_o   = b_id_q;
  assign b_resp_o = 2'b11;
  assign r_id_o   = r_id_q;
  assign r_data_o = DataWidth'(RespData);
  assign r_resp_o = 2'b11;
  assign r_last_o = (r_state_q == R_DATA) && (cnt_q == 8'd0);

endmodule
